wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter N_SRC, default 3; number of result sources (0=ALU, 1=MUL, 2=LSU).
REQ-002 Parameter FIFO_DEPTH, default 2; entries per source buffer, power of two, >=2.
REQ-003 Port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port flush  input  1  discards all buffered results.
REQ-006 Port src_valid  input  N_SRC  per-source result valid.
REQ-007 Port src_ready  output  N_SRC  per-source buffer can accept.
REQ-008 Port src_tag  input  N_SRC x 6  destination physical register per source.
REQ-009 Port src_data  input  N_SRC x 32  result value per source.
REQ-010 Port rf_we  output  1  physical register file write enable, registered.
REQ-011 Port rf_waddr  output  6  write physical register, registered.
REQ-012 Port rf_wdata  output  32  write data, registered.
REQ-013 Port pending  output  1  high when any source buffer holds an entry.

Function
REQ-014 Source i transfer occurs on a rising edge with src_valid[i] and src_ready[i] both high; the {tag,data} pair enters buffer i in order.
REQ-015 src_ready[i] is high iff buffer i is not full and flush is low; it has no combinational dependence on src_valid.
REQ-016 A transfer with tag 0 is accepted and discarded; it never occupies a buffer entry or a write slot.
REQ-017 Each cycle, at most one buffer head is granted; the grant pops that head on the next edge and loads rf_we=1, rf_waddr, rf_wdata from it.
REQ-018 No pending head in a cycle: rf_we is 0 after the next edge; rf_waddr/rf_wdata hold their previous values.
REQ-019 Arbitration is round-robin: the search starts at source (last_grant+1) mod N_SRC; last_grant updates only on a grant.
REQ-020 Latency: a result accepted on edge E with empty buffers and no competition drives rf_we=1 in the cycle after edge E+1.
REQ-021 Push and pop on the same buffer in the same edge are legal; occupancy is unchanged; a full buffer does not accept in that cycle (no pop-through).
REQ-022 Per source, results reach the write port in acceptance order; across sources the order follows the arbitration only.
REQ-023 flush high at an edge: all buffers empty, no push taken, rf_we=0 after that edge; last_grant is retained.
REQ-024 pending is combinational from buffer occupancy and is 0 in the cycle after a flush edge.

Reset
REQ-025 rst_n low at an edge: all buffers empty, rf_we=0, rf_waddr=0, rf_wdata=0, last_grant=N_SRC-1, so source 0 has first priority.
REQ-026 Reset during active traffic drops all buffered and in-flight results; src_ready is 0 while rst_n is low.

Configuration
REQ-027 Macro WB_STATS_EN defined: add outputs stat_writes (32) counting rf_we=1 cycles and stat_stalls (32) counting cycles with any src_valid&~src_ready; both wrap modulo 2^32, clear on reset, and are not cleared by flush.
REQ-028 WB_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.

Structure
REQ-029 Package wb_pkg holds PREG_W=6, XLEN=32, and typedef wb_entry_t {tag[PREG_W], data[XLEN]}.
REQ-030 One sub-module, wb_fifo: a synchronous FIFO of wb_entry_t with push, pop, flush, full, empty, and head outputs, instantiated N_SRC times.

Verification
REQ-031 Single ALU result tag=5 data=0xDEADBEEF at edge 1 -> rf_we=1, waddr=5, wdata=0xDEADBEEF in cycle after edge 2; pending then 0.
REQ-032 All three sources valid every cycle with distinct tags -> grants rotate 0,1,2,0,... and each source's tags appear in its issue order; no write is lost.
REQ-033 MUL pushes 3 results while arbitration is blocked by competing sources -> src_ready[1]=0 after 2 entries; stat_stalls increments (WB_STATS_EN).
REQ-034 Source tag 0 with data 0x1234 -> accepted, rf_we stays 0, pending stays 0.
REQ-035 Two buffered entries, then flush for one cycle -> rf_we=0 next cycle, pending=0, src_ready all 1 afterwards; then rst_n low mid-stream -> rf_we/rf_waddr/rf_wdata=0 and source 0 wins the first grant after reset.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the buffered write-back entry type for the write-back arbiter.
package wb_pkg;

    localparam int PREG_W = 6;
    localparam int XLEN   = 32;

    typedef struct packed {
        logic [PREG_W-1:0] tag;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source result buffer: synchronous FIFO of wb_entry_t with flush.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t wr_entry,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t     r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_do_push;
    logic          w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty     = (r_wptr == r_rptr);
    assign head      = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_do_push) r_mem[r_wptr[AW-1:0]] <= wr_entry;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: buffers results per source and writes one per cycle
// into the register file. Define WB_STATS_EN to add write/stall counters.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int N_SRC      = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    input  logic [N_SRC*PREG_W-1:0] src_tag,
    input  logic [N_SRC*XLEN-1:0]   src_data,
    output logic                    rf_we,
    output logic [PREG_W-1:0]       rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic                    pending
`ifdef WB_STATS_EN
    ,
    output logic [31:0]             stat_writes,
    output logic [31:0]             stat_stalls
`endif
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] w_full;
    logic [N_SRC-1:0] w_empty;
    logic [N_SRC-1:0] w_push;
    logic [N_SRC-1:0] w_pop;
    wb_entry_t        w_head [N_SRC];
    logic             w_grant_vld;
    logic [IDX_W-1:0] w_grant_idx;
    wb_entry_t        w_sel;
    logic [IDX_W-1:0] r_last_grant;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        wb_entry_t w_in;

        assign w_in.tag  = src_tag[gi*PREG_W +: PREG_W];
        assign w_in.data = src_data[gi*XLEN +: XLEN];
        // Ready never looks at src_valid; tag 0 handshakes but is dropped here.
        assign src_ready[gi] = rst_n && !flush && !w_full[gi];
        assign w_push[gi]    = src_valid[gi] && src_ready[gi] && (w_in.tag != '0);
        assign w_pop[gi]     = w_grant_vld && (w_grant_idx == IDX_W'(gi));

        wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .push     (w_push[gi]),
            .pop      (w_pop[gi]),
            .wr_entry (w_in),
            .full     (w_full[gi]),
            .empty    (w_empty[gi]),
            .head     (w_head[gi])
        );
    end

    assign pending = |(~w_empty);

    // Search starts one past the last granted source and wraps.
    always_comb begin
        int w_j;
        w_j         = 0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_sel       = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            w_j = int'(r_last_grant) + k;
            if (w_j >= N_SRC) w_j = w_j - N_SRC;
            if (!w_grant_vld && !w_empty[w_j]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = IDX_W'(w_j);
                w_sel       = w_head[w_j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            r_last_grant <= IDX_W'(N_SRC - 1);
        end else if (flush) begin
            rf_we <= 1'b0;
        end else begin
            rf_we <= w_grant_vld;
            if (w_grant_vld) begin
                rf_waddr     <= w_sel.tag;
                rf_wdata     <= w_sel.data;
                r_last_grant <= w_grant_idx;
            end
        end
    end

`ifdef WB_STATS_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_writes <= '0;
            stat_stalls <= '0;
        end else begin
            if (rf_we) stat_writes <= stat_writes + 32'd1;
            if (|(src_valid & ~src_ready)) stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [17:0] src_tag;
    logic [95:0] src_data;
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pending;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per source, plus write-port state.
    logic [37:0] mq [3][$];
    logic        m_we    = 1'b0;
    logic [5:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    int          m_last  = 2;

    wb_arbiter #(.N_SRC(3), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_tag   (src_tag),
        .src_data  (src_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] m_rdy();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = rst_n && !flush && (mq[i].size() < DEPTH);
        return r;
    endfunction

    function automatic logic m_pend();
        return (mq[0].size() + mq[1].size() + mq[2].size()) != 0;
    endfunction

    // Advance one rising edge and apply the specification's rules to the model.
    task automatic tick();
        logic [2:0]  rdy;
        logic [37:0] e;
        int          g;
        rdy = m_rdy();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_we = 0; m_waddr = '0; m_wdata = '0; m_last = 2;
        end else if (flush) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_we = 0;
        end else begin
            g = -1;
            for (int k = 1; k <= 3; k++)
                if (g < 0 && mq[(m_last + k) % 3].size() > 0) g = (m_last + k) % 3;
            if (g >= 0) begin
                e = mq[g].pop_front();
                m_we = 1; m_waddr = e[37:32]; m_wdata = e[31:0]; m_last = g;
            end else begin
                m_we = 0;
            end
            for (int i = 0; i < 3; i++)
                if (src_valid[i] && rdy[i] && src_tag[i*6 +: 6] != 6'd0)
                    mq[i].push_back({src_tag[i*6 +: 6], src_data[i*32 +: 32]});
        end
        #1;
    endtask

    task automatic set_src(input int s, input logic v, input logic [5:0] t, input logic [31:0] d);
        src_valid[s]      = v;
        src_tag[s*6 +: 6] = t;
        src_data[s*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst_n = 0; flush = 0; src_valid = 3'b111; src_tag = 18'h0_1041; src_data = '1;
        #1;
        checks++; if (src_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", src_ready); end
        tick(); tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_we); end
        checks++; if (rf_waddr !== 6'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
        src_valid = '0; rst_n = 1;
        tick();
    endtask

    task automatic test_single();
        set_src(0, 1'b1, 6'd5, 32'hDEAD_BEEF);
        tick();
        src_valid = '0;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we_early: got %b want 0", rf_we); end
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL single_pending_held: got %b want 1", pending); end
        tick();
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", rf_we); end
        checks++; if (rf_waddr !== 6'd5) begin errors++; $display("FAIL single_waddr: got %0d want 5", rf_waddr); end
        checks++; if (rf_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wdata: got %h want deadbeef", rf_wdata); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL single_pending: got %b want 0", pending); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we_idle: got %b want 0", rf_we); end
        checks++; if (rf_waddr !== 6'd5) begin errors++; $display("FAIL single_waddr_hold: got %0d want 5", rf_waddr); end
    endtask

    task automatic test_tag_zero();
        set_src(0, 1'b1, 6'd0, 32'h0000_1234);
        #1;
        checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL tag0_ready: got %b want 1", src_ready[0]); end
        tick();
        src_valid = '0;
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL tag0_pending: got %b want 0", pending); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL tag0_we: got %b want 0", rf_we); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL tag0_we_late: got %b want 0", rf_we); end
    endtask

    task automatic test_rotation();
        int issue [3];
        int nxt [3];
        int src, tot_i, tot_w;
        logic [2:0] rdy;
        rst_n = 0; tick(); rst_n = 1;
        for (int s = 0; s < 3; s++) begin issue[s] = 0; nxt[s] = 0; end
        for (int cyc = 0; cyc < 15; cyc++) begin
            for (int s = 0; s < 3; s++)
                set_src(s, 1'b1, 6'(1 + s*16 + issue[s]), {8'hA0, 8'(s), 16'(issue[s])});
            #1;
            rdy = src_ready;
            tick();
            for (int s = 0; s < 3; s++) if (rdy[s]) issue[s]++;
            if (cyc >= 1) begin
                checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL rot_we: cyc %0d got %b want 1", cyc, rf_we); end
                src = (int'(rf_waddr) - 1) / 16;
                if (src > 2 || src < 0) src = 2;
                checks++; if (src !== (cyc - 1) % 3) begin errors++; $display("FAIL rot_order: cyc %0d got src %0d want %0d", cyc, src, (cyc - 1) % 3); end
                checks++; if (rf_waddr !== 6'(1 + src*16 + nxt[src])) begin errors++; $display("FAIL rot_tag: got %0d want %0d", rf_waddr, 1 + src*16 + nxt[src]); end
                checks++; if (rf_wdata !== {8'hA0, 8'(src), 16'(nxt[src])}) begin errors++; $display("FAIL rot_data: got %h", rf_wdata); end
                nxt[src]++;
            end
        end
        src_valid = '0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rf_we) begin
                src = (int'(rf_waddr) - 1) / 16;
                if (src > 2 || src < 0) src = 2;
                checks++; if (rf_waddr !== 6'(1 + src*16 + nxt[src])) begin errors++; $display("FAIL rot_drain_tag: got %0d want %0d", rf_waddr, 1 + src*16 + nxt[src]); end
                nxt[src]++;
            end
        end
        tot_i = issue[0] + issue[1] + issue[2];
        tot_w = nxt[0] + nxt[1] + nxt[2];
        checks++; if (tot_w !== tot_i) begin errors++; $display("FAIL rot_lost: writes %0d want %0d", tot_w, tot_i); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rot_drained: pending %b want 0", pending); end
    endtask

    task automatic test_back_pressure();
        int   mul_acc;
        logic saw_block;
        logic [2:0] rdy;
        rst_n = 0; tick(); rst_n = 1;
        mul_acc = 0; saw_block = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            set_src(0, 1'b1, 6'd20, 32'h1111_0000 + 32'(cyc));
            set_src(1, mul_acc < 3, 6'(30 + mul_acc), 32'h2222_0000 + 32'(mul_acc));
            set_src(2, 1'b1, 6'd40, 32'h3333_0000 + 32'(cyc));
            #1;
            checks++; if (src_ready !== m_rdy()) begin errors++; $display("FAIL bp_ready: got %b want %b", src_ready, m_rdy()); end
            if (src_valid[1] && !src_ready[1] && !saw_block) begin
                saw_block = 1;
                checks++; if (mul_acc !== 2) begin errors++; $display("FAIL bp_block_at: accepted %0d want 2", mul_acc); end
            end
            rdy = src_ready;
            tick();
            if (src_valid[1] && rdy[1]) mul_acc++;
            checks++; if (rf_we !== m_we || rf_waddr !== m_waddr) begin errors++; $display("FAIL bp_write: got %b/%0d want %b/%0d", rf_we, rf_waddr, m_we, m_waddr); end
        end
        checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL bp_never_blocked: got %b want 1", saw_block); end
        checks++; if (mul_acc !== 3) begin errors++; $display("FAIL bp_mul_count: got %0d want 3", mul_acc); end
        src_valid = '0;
        for (int n = 0; n < 20; n++) tick();
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL bp_drain: pending %b want 0", pending); end
    endtask

    task automatic test_flush_reset();
        rst_n = 0; tick(); rst_n = 1;
        set_src(0, 1'b1, 6'd7, 32'h7);
        set_src(1, 1'b1, 6'd8, 32'h8);
        tick();
        src_valid = '0;
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL fl_pending_pre: got %b want 1", pending); end
        flush = 1;
        #1;
        checks++; if (src_ready !== 3'b000) begin errors++; $display("FAIL fl_ready_during: got %b want 000", src_ready); end
        tick();
        flush = 0;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL fl_we: got %b want 0", rf_we); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL fl_pending: got %b want 0", pending); end
        checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL fl_ready_after: got %b want 111", src_ready); end
        for (int cyc = 0; cyc < 3; cyc++) begin
            for (int s = 0; s < 3; s++) set_src(s, 1'b1, 6'(11 + s), 32'(cyc));
            tick();
        end
        rst_n = 0;
        #1;
        checks++; if (src_ready !== 3'b000) begin errors++; $display("FAIL rs_ready: got %b want 000", src_ready); end
        tick();
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 6'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL rs_outputs: got %b/%0d/%h want 0/0/0", rf_we, rf_waddr, rf_wdata); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rs_pending: got %b want 0", pending); end
        rst_n = 1;
        for (int s = 0; s < 3; s++) set_src(s, 1'b1, 6'(21 + s), 32'hC0 + 32'(s));
        tick();
        src_valid = '0;
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 6'd21) begin errors++; $display("FAIL rs_first_grant: got %b/%0d want 1/21", rf_we, rf_waddr); end
        for (int n = 0; n < 6; n++) tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst_n = ($urandom % 64) != 0;
            flush = ($urandom % 24) == 0;
            for (int s = 0; s < 3; s++)
                set_src(s, 1'($urandom), ($urandom % 8 == 0) ? 6'd0 : 6'($urandom), $urandom);
            #1;
            checks++; if (src_ready !== m_rdy()) begin errors++; $display("FAIL rand_ready: cyc %0d got %b want %b", cyc, src_ready, m_rdy()); end
            checks++; if (pending !== m_pend()) begin errors++; $display("FAIL rand_pending: cyc %0d got %b want %b", cyc, pending, m_pend()); end
            tick();
            checks++; if (rf_we !== m_we) begin errors++; $display("FAIL rand_we: cyc %0d got %b want %b", cyc, rf_we, m_we); end
            checks++; if (rf_waddr !== m_waddr) begin errors++; $display("FAIL rand_waddr: cyc %0d got %0d want %0d", cyc, rf_waddr, m_waddr); end
            checks++; if (rf_wdata !== m_wdata) begin errors++; $display("FAIL rand_wdata: cyc %0d got %h want %h", cyc, rf_wdata, m_wdata); end
        end
        rst_n = 1; flush = 0; src_valid = '0;
        tick();
    endtask

    initial begin
        rst_n = 0; flush = 0; src_valid = '0; src_tag = '0; src_data = '0;
        test_reset();
        test_single();
        test_tag_zero();
        test_rotation();
        test_back_pressure();
        test_flush_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
